// File: rtl/lnrv_flush_ctrl_if.sv
// Flush-protocol bundle between the EXU/trap requesters, the IFU redirect port
// and lnrv_flush_ctrl. CNT_W must match the controller's CNT_W.
interface lnrv_flush_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             brch_flush_req;
  logic             brch_flush_ack;
  logic [31:0]      brch_flush_pc_op1;
  logic [31:0]      brch_flush_pc_op2;
  logic             trap_flush_req;
  logic             trap_flush_ack;
  logic [31:0]      trap_flush_pc;
  logic             pipe_kill;
  logic             ifu_redir_vld;
  logic             ifu_redir_rdy;
  logic [31:0]      ifu_redir_pc;
  logic [CNT_W-1:0] flush_cnt;

  // Requesters and IFU side.
  modport master (
    output brch_flush_req, brch_flush_pc_op1, brch_flush_pc_op2,
    output trap_flush_req, trap_flush_pc, ifu_redir_rdy,
    input  brch_flush_ack, trap_flush_ack, pipe_kill,
    input  ifu_redir_vld, ifu_redir_pc, flush_cnt
  );

  // Flush controller side.
  modport slave (
    input  brch_flush_req, brch_flush_pc_op1, brch_flush_pc_op2,
    input  trap_flush_req, trap_flush_pc, ifu_redir_rdy,
    output brch_flush_ack, trap_flush_ack, pipe_kill,
    output ifu_redir_vld, ifu_redir_pc, flush_cnt
  );
endinterface

// File: rtl/lnrv_flush_ctrl.sv
// Pipeline-flush responder: arbitrates branch/trap flushes, kills IFU/IDU, redirects the IFU.
// Optional LNRV_FLUSH_BYPASS_EN: zero-cycle redirect when the IFU is ready in the ack cycle.
module lnrv_flush_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  lnrv_flush_ctrl_if.slave fl
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic             vld_q;
  logic             kill_q;
  logic [CNT_W-1:0] cnt_q;

  logic        trap_ack;
  logic        brch_ack;
  logic        any_ack;
  logic        bypass;
  logic [31:0] brch_sum;
  logic [31:0] tgt;

  // NOTE: every always_comb output gets a default first, otherwise paths that
  // skip an assignment infer a latch.
  always_comb begin
    trap_ack = 1'b0;
    brch_ack = 1'b0;
    if (state_q == IDLE) begin
      trap_ack = fl.trap_flush_req;
      brch_ack = fl.brch_flush_req & ~fl.trap_flush_req;
    end
  end

  assign any_ack  = trap_ack | brch_ack;
  assign brch_sum = fl.brch_flush_pc_op1 + fl.brch_flush_pc_op2;
  assign tgt      = trap_ack ? fl.trap_flush_pc : {brch_sum[31:1], 1'b0};

`ifdef LNRV_FLUSH_BYPASS_EN
  assign bypass = any_ack & fl.ifu_redir_rdy;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b1;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      kill_q <= any_ack;
      if (any_ack) cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        BOOT, REDIR: begin
          if (fl.ifu_redir_rdy) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
          end
        end
        IDLE: begin
          // A bypassed redirect is consumed in the ack cycle, so no REDIR visit.
          if (any_ack && !bypass) begin
            state_q <= REDIR;
            vld_q   <= 1'b1;
            pc_q    <= tgt;
          end
        end
        default: begin
          state_q <= BOOT;
          vld_q   <= 1'b1;
          pc_q    <= RESET_PC;
        end
      endcase
    end
  end

  assign fl.trap_flush_ack = trap_ack;
  assign fl.brch_flush_ack = brch_ack;
  assign fl.pipe_kill      = kill_q;
  assign fl.ifu_redir_vld  = vld_q | bypass;
  assign fl.ifu_redir_pc   = bypass ? tgt : pc_q;
  assign fl.flush_cnt      = cnt_q;

endmodule
